// File: rtl/prim_dstack.sv
// ============================================================================
// prim_dstack : T/N register stack with spill array, overflow/underflow flags
// Revision    : 1.0
// ============================================================================
`default_nettype none

module prim_dstack #(
  parameter int WIDTH = 16,
  parameter int DSS   = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_t,
  output logic [WIDTH-1:0] o_n,
  output logic [WIDTH-1:0] o_third,
  output logic [DSS+1:0]   o_depth,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int            c_mem_depth = 2 ** DSS;
  localparam logic [DSS+1:0] c_max      = (DSS+2)'(c_mem_depth + 2);
  localparam logic [DSS+1:0] c_two      = (DSS+2)'(2);

  localparam logic [3:0] c_op_push  = 4'd1;
  localparam logic [3:0] c_op_drop  = 4'd2;
  localparam logic [3:0] c_op_repl  = 4'd3;
  localparam logic [3:0] c_op_binop = 4'd4;
  localparam logic [3:0] c_op_dup   = 4'd5;
  localparam logic [3:0] c_op_over  = 4'd6;
  localparam logic [3:0] c_op_swap  = 4'd7;
  localparam logic [3:0] c_op_nip   = 4'd8;
  localparam logic [3:0] c_op_rot   = 4'd9;
  localparam logic [3:0] c_op_nrot  = 4'd10;

  logic [WIDTH-1:0] r_t, r_n;
  logic [DSS-1:0]   r_sp;
  logic [DSS+1:0]   r_depth;
  logic             r_ov, r_un;
  logic [WIDTH-1:0] r_mem [c_mem_depth];

  logic [1:0]       w_need;
  logic             w_inc, w_dec, w_under, w_over, w_exec, w_spill, w_fill;
  logic [DSS-1:0]   w_sp_m1;
  logic [WIDTH-1:0] w_third, w_t_nxt, w_n_nxt, w_mem_wd;
  logic             w_mem_we;
  logic [DSS-1:0]   w_mem_wa;

  // At full depth sp wraps to 0 modulo 2^DSS; sp-1 still addresses the third entry.
  assign w_sp_m1 = r_sp - DSS'(1);
  assign w_third = r_mem[w_sp_m1];

  always_comb begin
    w_need = 2'd0;
    w_inc  = 1'b0;
    w_dec  = 1'b0;
    case (i_op)
      c_op_push:  begin w_need = 2'd0; w_inc = 1'b1; end
      c_op_drop:  begin w_need = 2'd1; w_dec = 1'b1; end
      c_op_repl:  w_need = 2'd1;
      c_op_binop: begin w_need = 2'd2; w_dec = 1'b1; end
      c_op_dup:   begin w_need = 2'd1; w_inc = 1'b1; end
      c_op_over:  begin w_need = 2'd2; w_inc = 1'b1; end
      c_op_swap:  w_need = 2'd2;
      c_op_nip:   begin w_need = 2'd2; w_dec = 1'b1; end
      c_op_rot:   w_need = 2'd3;
      c_op_nrot:  w_need = 2'd3;
      default:    w_need = 2'd0;
    endcase
  end

  assign w_under = r_depth < {{DSS{1'b0}}, w_need};
  assign w_over  = w_inc && (r_depth == c_max);
  assign w_exec  = !w_under && !w_over;
  assign w_spill = w_inc && (r_depth >= c_two);
  assign w_fill  = w_dec && (r_depth > c_two);

  always_comb begin
    w_t_nxt  = r_t;
    w_n_nxt  = r_n;
    w_mem_we = 1'b0;
    w_mem_wa = r_sp;
    w_mem_wd = r_n;
    if (w_exec) begin
      case (i_op)
        c_op_push:  begin w_n_nxt = r_t; w_t_nxt = i_dat; w_mem_we = w_spill; end
        c_op_drop:  begin w_t_nxt = r_n; w_n_nxt = w_third; end
        c_op_repl:  w_t_nxt = i_dat;
        c_op_binop: begin w_t_nxt = i_dat; w_n_nxt = w_third; end
        c_op_dup:   begin w_n_nxt = r_t; w_mem_we = w_spill; end
        c_op_over:  begin w_t_nxt = r_n; w_n_nxt = r_t; w_mem_we = w_spill; end
        c_op_swap:  begin w_t_nxt = r_n; w_n_nxt = r_t; end
        c_op_nip:   w_n_nxt = w_third;
        c_op_rot: begin
          w_t_nxt  = w_third;
          w_n_nxt  = r_t;
          w_mem_we = 1'b1;
          w_mem_wa = w_sp_m1;
          w_mem_wd = r_n;
        end
        c_op_nrot: begin
          w_t_nxt  = r_n;
          w_n_nxt  = w_third;
          w_mem_we = 1'b1;
          w_mem_wa = w_sp_m1;
          w_mem_wd = r_t;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_t     <= '0;
      r_n     <= '0;
      r_sp    <= '0;
      r_depth <= '0;
      r_ov    <= 1'b0;
      r_un    <= 1'b0;
    end else begin
      r_t <= w_t_nxt;
      r_n <= w_n_nxt;
      if (w_exec && w_spill)     r_sp <= r_sp + DSS'(1);
      else if (w_exec && w_fill) r_sp <= w_sp_m1;
      if (w_exec && w_inc)       r_depth <= r_depth + (DSS+2)'(1);
      else if (w_exec && w_dec)  r_depth <= r_depth - (DSS+2)'(1);
      // A new error in the same cycle as a clear leaves the flag set.
      r_ov <= w_over  | (r_ov & ~i_clr_err);
      r_un <= w_under | (r_un & ~i_clr_err);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_wa] <= w_mem_wd;
  end

  assign o_t         = r_t;
  assign o_n         = r_n;
  assign o_third     = w_third;
  assign o_depth     = r_depth;
  assign o_empty     = (r_depth == '0);
  assign o_full      = (r_depth == c_max);
  assign o_overflow  = r_ov;
  assign o_underflow = r_un;

endmodule

`default_nettype wire

// File: tb/tb_prim_dstack.sv
// ============================================================================
// tb_prim_dstack : scoreboard bench for prim_dstack (WIDTH=16, DSS=2)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_prim_dstack;
  localparam int W    = 16;
  localparam int DSS  = 2;
  localparam int DW   = DSS + 2;
  localparam int MAXD = 6;

  localparam logic [3:0] NOP = 4'd0, PUSH = 4'd1, DROP = 4'd2, BINOP = 4'd4,
                         DUP = 4'd5, OVER = 4'd6, SWAP = 4'd7, NIP = 4'd8,
                         ROT = 4'd9, NROT = 4'd10, RSVD = 4'd12;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic [3:0]    i_op = 4'd0;
  logic [W-1:0]  i_dat = '0;
  logic          i_clr_err = 1'b0;
  logic [W-1:0]  o_t, o_n, o_third;
  logic [DW-1:0] o_depth;
  logic          o_empty, o_full, o_overflow, o_underflow;

  prim_dstack #(.WIDTH(W), .DSS(DSS)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_op(i_op), .i_dat(i_dat),
    .i_clr_err(i_clr_err), .o_t(o_t), .o_n(o_n), .o_third(o_third),
    .o_depth(o_depth), .o_empty(o_empty), .o_full(o_full),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  // mask = {check t, check n, check third}
  typedef struct {
    logic [W-1:0]  t, n, third;
    logic [DW-1:0] depth;
    logic          ov, un;
    logic [2:0]    mask;
    logic [63:0]   name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic compare(input exp_t e);
    logic bad;
    bad = (o_depth !== e.depth) || (o_empty !== (e.depth == 0)) ||
          (o_full !== (e.depth == DW'(MAXD))) ||
          (o_overflow !== e.ov) || (o_underflow !== e.un);
    if (e.mask[2] && (o_t !== e.t))         bad = 1'b1;
    if (e.mask[1] && (o_n !== e.n))         bad = 1'b1;
    if (e.mask[0] && (o_third !== e.third)) bad = 1'b1;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL %0s: got t=%h n=%h third=%h depth=%0d empty=%b full=%b ov=%b un=%b; want t=%h n=%h third=%h depth=%0d ov=%b un=%b (mask %b)",
               e.name, o_t, o_n, o_third, o_depth, o_empty, o_full, o_overflow, o_underflow,
               e.t, e.n, e.third, e.depth, e.ov, e.un, e.mask);
    end
  endtask

  always @(posedge i_clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      compare(mon_e);
    end
  end

  function automatic exp_t mk(input logic [63:0] name, input logic [W-1:0] t, n, th,
                              input int d, input logic ov, un, input logic [2:0] mask);
    exp_t e;
    e.name = name; e.t = t; e.n = n; e.third = th;
    e.depth = DW'(d); e.ov = ov; e.un = un; e.mask = mask;
    return e;
  endfunction

  task automatic op(input logic [3:0] code, input logic [W-1:0] dat, input logic clr,
                    input exp_t e);
    @(negedge i_clk);
    i_op = code; i_dat = dat; i_clr_err = clr;
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge i_clk);
    i_op = NOP; i_dat = '0; i_clr_err = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    compare(mk("reset", 16'h0, 16'h0, 16'h0, 0, 0, 0, 3'b110));

    // push and rotate
    op(PUSH, 16'h1111, 0, mk("push1", 16'h1111, 16'h0000, 16'h0, 1, 0, 0, 3'b110));
    op(PUSH, 16'h2222, 0, mk("push2", 16'h2222, 16'h1111, 16'h0, 2, 0, 0, 3'b110));
    op(PUSH, 16'h3333, 0, mk("push3", 16'h3333, 16'h2222, 16'h1111, 3, 0, 0, 3'b111));
    op(ROT,  16'h0,    0, mk("rot",   16'h1111, 16'h3333, 16'h2222, 3, 0, 0, 3'b111));
    op(NROT, 16'h0,    0, mk("nrot",  16'h3333, 16'h2222, 16'h1111, 3, 0, 0, 3'b111));

    // binary op
    do_reset();
    op(PUSH,  16'h5, 0, mk("bpush5", 16'h5, 16'h0, 16'h0, 1, 0, 0, 3'b110));
    op(PUSH,  16'h7, 0, mk("bpush7", 16'h7, 16'h5, 16'h0, 2, 0, 0, 3'b110));
    op(BINOP, 16'hC, 0, mk("binop",  16'hC, 16'h0, 16'h0, 1, 0, 0, 3'b100));
    op(DROP,  16'h0, 0, mk("bdrop",  16'h0, 16'h0, 16'h0, 0, 0, 0, 3'b000));

    // overflow and readback
    do_reset();
    for (int k = 1; k <= MAXD; k++)
      op(PUSH, W'(k), 0, mk("ofpush", W'(k), W'(k-1), W'(k-2), k, 0, 0,
                            (k >= 3) ? 3'b111 : 3'b110));
    op(PUSH, 16'h7, 0, mk("ofpush7", 16'h6, 16'h5, 16'h4, 6, 1, 0, 3'b111));
    op(NOP,  16'h0, 1, mk("ofclr",   16'h6, 16'h5, 16'h4, 6, 0, 0, 3'b111));
    for (int d = MAXD - 1; d >= 1; d--)
      op(DROP, 16'h0, 0, mk("ofdrop", W'(d), W'(d-1), W'(d-2), d, 0, 0,
                            (d >= 3) ? 3'b111 : ((d == 2) ? 3'b110 : 3'b100)));
    op(DROP, 16'h0, 0, mk("ofdrop0", 16'h0, 16'h0, 16'h0, 0, 0, 0, 3'b000));

    // underflow
    do_reset();
    op(SWAP, 16'h0, 0, mk("ufswap", 16'h0, 16'h0, 16'h0, 0, 0, 1, 3'b110));
    op(PUSH, 16'h9, 0, mk("ufpush",  16'h9, 16'h0, 16'h0, 1, 0, 1, 3'b110));
    op(ROT,  16'h0, 1, mk("ufrotclr", 16'h9, 16'h0, 16'h0, 1, 0, 1, 3'b110));
    op(NOP,  16'h0, 1, mk("ufclr",   16'h9, 16'h0, 16'h0, 1, 0, 0, 3'b110));
    op(RSVD, 16'hF, 0, mk("rsvd",    16'h9, 16'h0, 16'h0, 1, 0, 0, 3'b110));

    // stack shuffles
    do_reset();
    op(PUSH, 16'hA, 0, mk("shpushA", 16'hA, 16'h0, 16'h0, 1, 0, 0, 3'b110));
    op(PUSH, 16'hB, 0, mk("shpushB", 16'hB, 16'hA, 16'h0, 2, 0, 0, 3'b110));
    op(OVER, 16'h0, 0, mk("over",    16'hA, 16'hB, 16'hA, 3, 0, 0, 3'b111));
    op(NIP,  16'h0, 0, mk("nip",     16'hA, 16'hA, 16'h0, 2, 0, 0, 3'b110));
    op(DUP,  16'h0, 0, mk("dup",     16'hA, 16'hA, 16'hA, 3, 0, 0, 3'b111));

    // asynchronous reset mid-sequence
    do_reset();
    for (int k = 1; k <= 4; k++)
      op(PUSH, W'(k), 0, mk("rpush", W'(k), W'(k-1), W'(k-2), k, 0, 0,
                            (k >= 3) ? 3'b111 : 3'b110));
    idle();
    #2 i_reset = 1'b1;
    #1 compare(mk("asyncrst", 16'h0, 16'h0, 16'h0, 0, 0, 0, 3'b110));
    #1 i_reset = 1'b0;
    op(PUSH, 16'hBEEF, 0, mk("beef", 16'hBEEF, 16'h0, 16'h0, 1, 0, 0, 3'b110));
    idle();

    repeat (4) @(posedge i_clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
